// File: rtl/vcve2_bht_branch_predict_pkg.sv
// Shared types and constants for the vcve2 branch history table predictor.
// Opcode values, the decoded branch-class flags and the counter reset value.
package vcve2_bht_branch_predict_pkg;

    typedef enum logic [6:0] {
        OPCODE_BRANCH = 7'h63,
        OPCODE_JAL    = 7'h6f
    } opcode_e;

    typedef struct packed {
        logic j;
        logic b;
        logic cj;
        logic cb;
    } br_class_t;

    // Weakly not-taken: the value just below the counter midpoint.
    function automatic int unsigned bht_ctr_init_fn(int unsigned width);
        return (32'd1 << (width - 32'd1)) - 32'd1;
    endfunction

endpackage

// File: rtl/vcve2_bht_branch_predict_if.sv
// Fetch/update/prediction bundle between the fetch stage and the branch predictor.
// master drives fetch and training inputs; slave is the predictor.
interface vcve2_bht_branch_predict_if;

    logic [31:0] fetch_rdata_i;
    logic [31:0] fetch_pc_i;
    logic        fetch_valid_i;
    logic        predict_branch_taken_o;
    logic [31:0] predict_branch_pc_o;
    logic        update_valid_i;
    logic [31:0] update_pc_i;
    logic        update_taken_i;
    logic        clear_i;

    modport master (
        output fetch_rdata_i, fetch_pc_i, fetch_valid_i,
        output update_valid_i, update_pc_i, update_taken_i, clear_i,
        input  predict_branch_taken_o, predict_branch_pc_o
    );

    modport slave (
        input  fetch_rdata_i, fetch_pc_i, fetch_valid_i,
        input  update_valid_i, update_pc_i, update_taken_i, clear_i,
        output predict_branch_taken_o, predict_branch_pc_o
    );

endinterface

// File: rtl/vcve2_bht_branch_predict_bht.sv
// Branch history table: saturating counter plus trained flag per entry,
// one combinational read port, one write port, clear and synchronous reset.
module vcve2_bht
    import vcve2_bht_branch_predict_pkg::*;
#(
    parameter int unsigned NumEntries   = 64,
    parameter int unsigned CounterWidth = 2,
    localparam int unsigned IdxW        = $clog2(NumEntries)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic [IdxW-1:0]         rd_idx_i,
    output logic [CounterWidth-1:0] rd_ctr_o,
    output logic                    rd_trained_o,
    input  logic                    wr_valid_i,
    input  logic [IdxW-1:0]         wr_idx_i,
    input  logic                    wr_taken_i
);

    localparam logic [CounterWidth-1:0] CtrInit = CounterWidth'(bht_ctr_init_fn(CounterWidth));
    localparam logic [CounterWidth-1:0] CtrMax  = '1;

    logic [CounterWidth-1:0] ctr_q [NumEntries];
    logic [NumEntries-1:0]   trained_q;

    // Clear shares the reset path, so a coincident update is dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            for (int unsigned i = 0; i < NumEntries; i++) begin
                ctr_q[IdxW'(i)] <= CtrInit;
            end
            trained_q <= '0;
        end else if (wr_valid_i) begin
            if (wr_taken_i) begin
                if (ctr_q[wr_idx_i] != CtrMax) begin
                    ctr_q[wr_idx_i] <= ctr_q[wr_idx_i] + 1'b1;
                end
            end else if (ctr_q[wr_idx_i] != '0) begin
                ctr_q[wr_idx_i] <= ctr_q[wr_idx_i] - 1'b1;
            end
            trained_q[wr_idx_i] <= 1'b1;
        end
    end

    assign rd_ctr_o     = ctr_q[rd_idx_i];
    assign rd_trained_o = trained_q[rd_idx_i];

endmodule

// File: rtl/vcve2_bht_branch_predict.sv
// Dynamic branch predictor: decodes RV32/RVC branches and jumps, forms the
// target, and picks conditional direction from the branch history table.
module vcve2_bht_branch_predict
    import vcve2_bht_branch_predict_pkg::*;
#(
    parameter int unsigned NumEntries     = 64,
    parameter int unsigned CounterWidth   = 2,
    parameter logic        StaticFallback = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    vcve2_bht_branch_predict_if.slave  bus
);

    localparam int unsigned IdxW = $clog2(NumEntries);

    if (NumEntries < 2 || (NumEntries & (NumEntries - 1)) != 0) begin : g_bad_entries
        $error("NumEntries must be a power of two and at least 2");
    end
    if (CounterWidth < 1 || CounterWidth > 4) begin : g_bad_ctr_width
        $error("CounterWidth must be in 1..4");
    end

    br_class_t               cls;
    logic [31:0]             instr;
    logic [31:0]             imm_j, imm_b, imm_cj, imm_cb, imm;
    logic [CounterWidth-1:0] rd_ctr;
    logic                    rd_trained;
    logic                    dir;
    logic                    unused_pc_bits;

    always_comb begin
        instr  = bus.fetch_rdata_i;
        cls.j  = instr[6:0] == OPCODE_JAL;
        cls.b  = instr[6:0] == OPCODE_BRANCH;
        cls.cj = instr[1:0] == 2'b01 && (instr[15:13] == 3'b001 || instr[15:13] == 3'b101);
        cls.cb = instr[1:0] == 2'b01 && instr[15:14] == 2'b11;

        imm_j  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_cj = {{21{instr[12]}}, instr[8], instr[10:9], instr[6], instr[7], instr[2],
                  instr[11], instr[5:3], 1'b0};
        imm_cb = {{24{instr[12]}}, instr[6:5], instr[2], instr[11:10], instr[4:3], 1'b0};

        // Non-branch fetches fall through to the B-type immediate.
        if (cls.j) begin
            imm = imm_j;
        end else if (cls.cj) begin
            imm = imm_cj;
        end else if (cls.cb) begin
            imm = imm_cb;
        end else begin
            imm = imm_b;
        end

        if (StaticFallback && !rd_trained) begin
            dir = imm[31];
        end else begin
            dir = rd_ctr[CounterWidth-1];
        end
    end

    vcve2_bht #(
        .NumEntries  (NumEntries),
        .CounterWidth(CounterWidth)
    ) u_bht (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (bus.clear_i),
        .rd_idx_i    (bus.fetch_pc_i[IdxW:1]),
        .rd_ctr_o    (rd_ctr),
        .rd_trained_o(rd_trained),
        .wr_valid_i  (bus.update_valid_i),
        .wr_idx_i    (bus.update_pc_i[IdxW:1]),
        .wr_taken_i  (bus.update_taken_i)
    );

    assign bus.predict_branch_pc_o    = bus.fetch_pc_i + imm;
    assign bus.predict_branch_taken_o = bus.fetch_valid_i &
                                        (cls.j | cls.cj | ((cls.b | cls.cb) & dir));

    assign unused_pc_bits = ^{bus.update_pc_i[31:IdxW+1], bus.update_pc_i[0]};

    a_class_onehot0: assert property (@(posedge clk_i)
        bus.fetch_valid_i |-> $onehot0({cls.j, cls.b, cls.cj, cls.cb}));

endmodule
